spi_slave_shifter: RTL and testbench
====================================

// Module: spi_slave_shifter
// PURPOSE
//  SPI slave data path, directly downstream of the SCK/CS edge detector. Consumes its
//  clk-domain pulses (first/second SCK edge, frame start/finish): samples MOSI, drives MISO,
//  counts bits to a run-time word length, and exchanges whole words with the core logic
//  through valid/ready handshakes. MSB first; multi-word frames supported.
// PARAMETERS
//  SPI_MAX_WIDTH_LOG  4  log2 of max word length; MAXW = 2**SPI_MAX_WIDTH_LOG (16)
// PORTS
//  clk              in   1     system clock
//  rst_n            in   1     asynchronous reset, active low
//  cpha             in   1     0: sample on first edge, shift on second; 1: the reverse
//  spi_width        in   LOG   word length minus 1 (0 -> 1 bit, 15 -> 16 bits)
//  sck_first_edge   in   1     1-cycle pulse, leading SCK edge
//  sck_second_edge  in   1     1-cycle pulse, trailing SCK edge
//  spi_start        in   1     1-cycle pulse, CS fell
//  spi_finish       in   1     1-cycle pulse, CS rose
//  mosi             in   1     serial data in (already synchronised)
//  miso             out  1     serial data out
//  miso_oe          out  1     MISO output enable (high while frame active)
//  tx_data          in   MAXW  next word to send, right-aligned
//  tx_valid         in   1     tx_data valid
//  tx_ready         out  1     tx holding register empty
//  tx_underrun      out  1     1-cycle pulse: word loaded while holding register empty
//  rx_data          out  MAXW  last received word, right-aligned, upper bits zero
//  rx_valid         out  1     rx_data valid, held until rx_ready
//  rx_ready         in   1     consumer accepts rx_data
//  rx_overrun       out  1     1-cycle pulse: word completed while rx_valid && !rx_ready
//  frame_active     out  1     high from spi_start to spi_finish
// BEHAVIOUR
//  - Reset: FSM IDLE; miso=0, miso_oe=0, tx_ready=1, tx_underrun=0, rx_data=0,
//    rx_valid=0, rx_overrun=0, frame_active=0; shifters, counters, and flags cleared.
//  - FSM IDLE->ACTIVE on spi_start; ACTIVE->IDLE on spi_finish. spi_start while ACTIVE
//    restarts the frame. spi_start and spi_finish in the same cycle: finish wins, go IDLE.
//  - spi_start: latch len = spi_width + 1 and cpha for the frame. Load tx_shift from the
//    holding register (or zeros plus tx_underrun). bit_cnt=0, sampled=0.
//  - Sample edge: rx_shift <= {rx_shift, mosi}, bit_cnt++, sampled=1. When bit_cnt==len-1,
//    wrap bit_cnt to 0, set word_done, and present the word on rx_data with rx_valid=1
//    in the next cycle.
//  - Shift edge: ignored while sampled==0 (this protects the first bit in cpha=1 mode).
//    Otherwise: if word_done, load next word, clear word_done and sampled; else
//    tx_shift <<= 1, sampled=0.
//  - miso = tx_shift[len-1], registered; miso_oe = frame_active.
//  - Edge pulses in IDLE are ignored. Both edge pulses in one cycle cannot occur; if they
//    do, the sample edge is applied first.
//  - tx holding: accept on tx_valid && tx_ready (tx_ready drops the next cycle); emptied on
//    load. A write and a load in the same cycle: load takes the old word, the new word is
//    stored, tx_ready stays 0.
//  - rx: rx_valid clears on rx_ready. On completion with rx_valid && !rx_ready: keep the
//    old data, drop the new word, pulse rx_overrun. Completion in the same cycle as
//    rx_ready: new word replaces old, rx_valid stays 1.
//  - spi_finish mid-word: discard the partial word (no rx_valid). An unsent tx word stays
//    held for the next frame.
//  - spi_width changes mid-frame have no effect until the next spi_start.
// STRUCTURE
//  - spi_pkg: MAXW localparam, FSM state encoding (IDLE, ACTIVE), mode bit names.
//  - One sub-module, spi_word_buffer (single-entry valid/ready holding register),
//    instantiated for both tx and rx. Counters, shifters, and the FSM stay top-level.
// TESTING
//  - cpha=0, width=7, tx=0xA5, 8 edge pairs with MOSI=0x3C -> MISO bits 1,0,1,0,0,1,0,1;
//    rx_data=0x3C, rx_valid 1 cycle after the 8th sample.
//  - cpha=1, width=15, tx=0xBEEF, first leading edge masked upstream -> MISO 0xBEEF MSB
//    first; rx 16-bit word correct.
//  - 3-word frame with width=3, tx given only twice -> third word 0 with tx_underrun
//    pulse; rx_ready low -> rx_overrun on word 2, rx_data keeps word 1.
//  - spi_finish after 5 of 8 bits -> no rx_valid; next frame receives a clean 8-bit word,
//    bit_cnt restarted from 0.
//  - Edge pulses in IDLE, plus simultaneous start+finish -> no state change, miso_oe=0.
//  - rst_n asserted mid-word -> all outputs at reset values immediately; next frame
//    correct.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave data path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_pkg;

    // Default word-length exponent; the widest word is 2**SPI_MAX_WIDTH_LOG bits.
    localparam int SPI_MAX_WIDTH_LOG_DEF = 4;
    localparam int MAXW                  = 2 ** SPI_MAX_WIDTH_LOG_DEF;

    // Frame-level FSM encoding.
    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;

    // cpha values: which SCK edge samples MOSI.
    localparam logic CPHA_SAMPLE_FIRST  = 1'b0;
    localparam logic CPHA_SAMPLE_SECOND = 1'b1;

endpackage

// File: rtl/spi_word_buffer.sv
// Single-entry valid/ready holding register for one SPI word.
// Latency: 1 cycle from accepted input to out_vld.
// Backpressure: in_rdy low while full; with PASS_THRU, a same-cycle pop frees the slot.
module spi_word_buffer #(
    parameter int W         = 16,
    parameter bit PASS_THRU = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_dat
);

    logic         full_q;
    logic         full_d;
    logic [W-1:0] dat_q;
    logic [W-1:0] dat_d;
    logic         push;
    logic         pop;

    // Handshake terms kept as separate assigns so ready never depends on valid.
    assign pop     = full_q && out_rdy;
    assign in_rdy  = !full_q || (PASS_THRU && out_rdy);
    assign push    = in_vld && in_rdy;
    assign out_vld = full_q;
    assign out_dat = dat_q;

    // Next occupancy and contents: a push always wins over a pop.
    always_comb begin
        full_d = full_q;
        dat_d  = dat_q;
        if (push) begin
            full_d = 1'b1;
            dat_d  = in_dat;
        end else if (pop) begin
            full_d = 1'b0;
        end
    end

    // Storage register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            dat_q  <= '0;
        end else begin
            full_q <= full_d;
            dat_q  <= dat_d;
        end
    end

endmodule

// File: rtl/spi_slave_shifter.sv
// SPI slave data path: samples MOSI, drives MISO, exchanges words with the core.
// Latency: rx word valid 1 cycle after its last sample edge; MISO updates the cycle after an edge.
// Backpressure: tx_ready low while a word is held; rx words dropped with rx_overrun if rx is full.
module spi_slave_shifter
    import spi_pkg::*;
#(
    parameter int SPI_MAX_WIDTH_LOG = SPI_MAX_WIDTH_LOG_DEF
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cpha,
    input  logic [SPI_MAX_WIDTH_LOG-1:0]    spi_width,
    input  logic                            sck_first_edge,
    input  logic                            sck_second_edge,
    input  logic                            spi_start,
    input  logic                            spi_finish,
    input  logic                            mosi,
    output logic                            miso,
    output logic                            miso_oe,
    input  logic [2**SPI_MAX_WIDTH_LOG-1:0] tx_data,
    input  logic                            tx_valid,
    output logic                            tx_ready,
    output logic                            tx_underrun,
    output logic [2**SPI_MAX_WIDTH_LOG-1:0] rx_data,
    output logic                            rx_valid,
    input  logic                            rx_ready,
    output logic                            rx_overrun,
    output logic                            frame_active
);

    localparam int LOG = SPI_MAX_WIDTH_LOG;
    localparam int DW  = 2 ** LOG;

    spi_state_e    state_q, state_d;
    logic [LOG-1:0] width_q, width_d;
    logic           cpha_q, cpha_d;
    logic [LOG-1:0] bit_cnt_q, bit_cnt_d;
    logic           sampled_q, sampled_d;
    logic           word_done_q, word_done_d;
    logic [DW-1:0]  tx_shift_q, tx_shift_d;
    logic [DW-1:0]  rx_shift_q, rx_shift_d;
    logic           miso_q, miso_d;
    logic           tx_underrun_q, tx_underrun_d;
    logic           rx_overrun_q, rx_overrun_d;

    logic           sample_edge;
    logic           shift_edge;
    logic           frame_run;
    logic           tx_load;
    logic           tx_hold_vld;
    logic [DW-1:0]  tx_hold_dat;
    logic           rx_push_vld;
    logic           rx_push_rdy;
    logic [DW-1:0]  rx_push_dat;

    // Outgoing word holding register; no pass-through so tx_ready means "empty".
    spi_word_buffer #(.W(DW), .PASS_THRU(1'b0)) u_tx_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (tx_valid),
        .in_rdy  (tx_ready),
        .in_dat  (tx_data),
        .out_vld (tx_hold_vld),
        .out_rdy (tx_load),
        .out_dat (tx_hold_dat)
    );

    // Received word register; a consume in the completion cycle lets the new word in.
    spi_word_buffer #(.W(DW), .PASS_THRU(1'b1)) u_rx_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (rx_push_vld),
        .in_rdy  (rx_push_rdy),
        .in_dat  (rx_push_dat),
        .out_vld (rx_valid),
        .out_rdy (rx_ready),
        .out_dat (rx_data)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: finish dominates a simultaneous start.
    always_comb begin
        state_d = state_q;
        if (spi_finish) begin
            state_d = IDLE;
        end else if (spi_start) begin
            state_d = ACTIVE;
        end
    end

    // FSM outputs: the frame is live while ACTIVE, and MISO is driven only then.
    always_comb begin
        frame_active = (state_q == ACTIVE);
        miso_oe      = (state_q == ACTIVE);
    end

    // Datapath: frame setup/teardown, then sample edge before shift edge.
    always_comb begin
        width_d       = width_q;
        cpha_d        = cpha_q;
        bit_cnt_d     = bit_cnt_q;
        sampled_d     = sampled_q;
        word_done_d   = word_done_q;
        tx_shift_d    = tx_shift_q;
        rx_shift_d    = rx_shift_q;
        tx_load       = 1'b0;
        tx_underrun_d = 1'b0;
        rx_push_vld   = 1'b0;
        rx_push_dat   = '0;
        rx_overrun_d  = 1'b0;
        sample_edge   = (cpha_q == CPHA_SAMPLE_SECOND) ? sck_second_edge : sck_first_edge;
        shift_edge    = (cpha_q == CPHA_SAMPLE_SECOND) ? sck_first_edge  : sck_second_edge;
        frame_run     = !spi_finish && (spi_start || (state_q == ACTIVE));

        if (spi_finish) begin
            // Partial words are discarded; an unsent held word stays for the next frame.
            bit_cnt_d   = '0;
            sampled_d   = 1'b0;
            word_done_d = 1'b0;
            tx_shift_d  = '0;
            rx_shift_d  = '0;
        end else if (spi_start) begin
            width_d       = spi_width;
            cpha_d        = cpha;
            bit_cnt_d     = '0;
            sampled_d     = 1'b0;
            word_done_d   = 1'b0;
            rx_shift_d    = '0;
            tx_load       = 1'b1;
            tx_shift_d    = tx_hold_vld ? tx_hold_dat : '0;
            tx_underrun_d = !tx_hold_vld;
        end else if (state_q == ACTIVE) begin
            if (sample_edge) begin
                rx_shift_d = {rx_shift_q[DW-2:0], mosi};
                sampled_d  = 1'b1;
                if (bit_cnt_q == width_q) begin
                    // Word complete: hand it over and restart accumulation from zero,
                    // which keeps the bits above the word length cleared.
                    bit_cnt_d    = '0;
                    word_done_d  = 1'b1;
                    rx_push_vld  = 1'b1;
                    rx_push_dat  = rx_shift_d;
                    rx_overrun_d = !rx_push_rdy;
                    rx_shift_d   = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            // A shift before any sample would lose the first bit in cpha=1 mode.
            if (shift_edge && sampled_d) begin
                sampled_d = 1'b0;
                if (word_done_d) begin
                    word_done_d   = 1'b0;
                    tx_load       = 1'b1;
                    tx_shift_d    = tx_hold_vld ? tx_hold_dat : '0;
                    tx_underrun_d = !tx_hold_vld;
                end else begin
                    tx_shift_d = tx_shift_q << 1;
                end
            end
        end

        miso_d = frame_run ? tx_shift_d[width_d] : 1'b0;
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            width_q       <= '0;
            cpha_q        <= 1'b0;
            bit_cnt_q     <= '0;
            sampled_q     <= 1'b0;
            word_done_q   <= 1'b0;
            tx_shift_q    <= '0;
            rx_shift_q    <= '0;
            miso_q        <= 1'b0;
            tx_underrun_q <= 1'b0;
            rx_overrun_q  <= 1'b0;
        end else begin
            width_q       <= width_d;
            cpha_q        <= cpha_d;
            bit_cnt_q     <= bit_cnt_d;
            sampled_q     <= sampled_d;
            word_done_q   <= word_done_d;
            tx_shift_q    <= tx_shift_d;
            rx_shift_q    <= rx_shift_d;
            miso_q        <= miso_d;
            tx_underrun_q <= tx_underrun_d;
            rx_overrun_q  <= rx_overrun_d;
        end
    end

    assign miso        = miso_q;
    assign tx_underrun = tx_underrun_q;
    assign rx_overrun  = rx_overrun_q;

endmodule

// File: tb/tb_spi_slave_shifter.sv
// Self-checking bench for spi_slave_shifter: vector table, directed corner cases, random frames.
// Latency: n/a.
// Backpressure: n/a.
module tb_spi_slave_shifter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpha = 1'b0;
    logic [3:0]  spi_width = '0;
    logic        sck_first_edge = 1'b0;
    logic        sck_second_edge = 1'b0;
    logic        spi_start = 1'b0;
    logic        spi_finish = 1'b0;
    logic        mosi = 1'b0;
    logic        miso;
    logic        miso_oe;
    logic [15:0] tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic        tx_underrun;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b1;
    logic        rx_overrun;
    logic        frame_active;

    always #5 clk = ~clk;

    spi_slave_shifter #(.SPI_MAX_WIDTH_LOG(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cpha            (cpha),
        .spi_width       (spi_width),
        .sck_first_edge  (sck_first_edge),
        .sck_second_edge (sck_second_edge),
        .spi_start       (spi_start),
        .spi_finish      (spi_finish),
        .mosi            (mosi),
        .miso            (miso),
        .miso_oe         (miso_oe),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .tx_underrun     (tx_underrun),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .rx_ready        (rx_ready),
        .rx_overrun      (rx_overrun),
        .frame_active    (frame_active)
    );

    int          n_chk = 0;
    int          n_pass = 0;
    logic        cur_cpha = 1'b0;
    logic        last_rxv;
    logic        last_ovr;
    logic [15:0] last_rxd;
    logic        udr_flag;

    typedef struct {
        logic        ph;
        logic [3:0]  width;
        logic [15:0] tx;
        logic [15:0] mo;
        logic [15:0] exp_miso;
        logic [15:0] exp_rx;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One idle cycle, then a one-cycle SCK edge pulse (lead=1: first edge).
    task automatic pulse(input logic lead);
        cyc();
        sck_first_edge  = lead;
        sck_second_edge = !lead;
        cyc();
        sck_first_edge  = 1'b0;
        sck_second_edge = 1'b0;
        if (tx_underrun) udr_flag = 1'b1;
    endtask

    // One SPI bit; mo is MISO as seen just before the sampling edge.
    task automatic do_bit(input logic b, output logic mo);
        if (cur_cpha) begin
            pulse(1'b1);
            mo = miso;
            mosi = b;
            pulse(1'b0);
        end else begin
            mo = miso;
            mosi = b;
            pulse(1'b1);
        end
        last_rxv = rx_valid;
        last_rxd = rx_data;
        last_ovr = rx_overrun;
        if (!cur_cpha) pulse(1'b0);
    endtask

    task automatic send_word(input int len, input logic [15:0] mo_word, output logic [15:0] got);
        logic b;
        got = '0;
        for (int i = len - 1; i >= 0; i--) begin
            do_bit(mo_word[i], b);
            got[i] = b;
        end
    endtask

    task automatic tx_write(input logic [15:0] w);
        tx_data  = w;
        tx_valid = 1'b1;
        cyc();
        tx_valid = 1'b0;
        tx_data  = 16'($urandom);
    endtask

    task automatic start_frame(input logic ph, input logic [3:0] w);
        cpha      = ph;
        cur_cpha  = ph;
        spi_width = w;
        spi_start = 1'b1;
        cyc();
        spi_start = 1'b0;
    endtask

    task automatic end_frame();
        spi_finish = 1'b1;
        cyc();
        spi_finish = 1'b0;
    endtask

    // Reference: a word of len bits is just the low len bits, sent/received MSB first.
    function automatic logic [15:0] mask_w(input logic [15:0] w, input int len);
        logic [31:0] m;
        m = (32'd1 << len) - 32'd1;
        return w & m[15:0];
    endfunction

    vec_t        vecs[6];
    logic [15:0] got;
    logic [15:0] mv;
    logic        b;
    logic        r_ph;
    int          r_len;
    int          r_nw;
    logic [15:0] r_tx[3];
    logic [15:0] r_mo[3];

    initial begin
        vecs[0] = '{1'b0, 4'd7,  16'h00A5, 16'h003C, 16'h00A5, 16'h003C};
        vecs[1] = '{1'b1, 4'd15, 16'hBEEF, 16'hC0DE, 16'hBEEF, 16'hC0DE};
        vecs[2] = '{1'b0, 4'd3,  16'h00F3, 16'h005A, 16'h0003, 16'h000A};
        vecs[3] = '{1'b1, 4'd0,  16'h0001, 16'hFFFF, 16'h0001, 16'h0001};
        vecs[4] = '{1'b1, 4'd4,  16'hFFF5, 16'h0033, 16'h0015, 16'h0013};
        vecs[5] = '{1'b0, 4'd15, 16'h8001, 16'h7FFE, 16'h8001, 16'h7FFE};

        // Reset values.
        rst_n = 1'b0;
        cyc();
        cyc();
        chk("reset miso", 32'(miso), 32'd0);
        chk("reset miso_oe", 32'(miso_oe), 32'd0);
        chk("reset tx_ready", 32'(tx_ready), 32'd1);
        chk("reset tx_underrun", 32'(tx_underrun), 32'd0);
        chk("reset rx_data", 32'(rx_data), 32'd0);
        chk("reset rx_valid", 32'(rx_valid), 32'd0);
        chk("reset rx_overrun", 32'(rx_overrun), 32'd0);
        chk("reset frame_active", 32'(frame_active), 32'd0);
        rst_n = 1'b1;
        cyc();

        // Single-word frames from the vector table.
        for (int v = 0; v < 6; v++) begin
            tx_write(vecs[v].tx);
            chk("vec tx_ready after write", 32'(tx_ready), 32'd0);
            start_frame(vecs[v].ph, vecs[v].width);
            chk("vec start underrun", 32'(tx_underrun), 32'd0);
            chk("vec miso_oe", 32'(miso_oe), 32'd1);
            send_word(int'(vecs[v].width) + 1, vecs[v].mo, got);
            chk("vec miso word", 32'(got), 32'(vecs[v].exp_miso));
            chk("vec rx_valid", 32'(last_rxv), 32'd1);
            chk("vec rx_data", 32'(last_rxd), 32'(vecs[v].exp_rx));
            end_frame();
            chk("vec frame_active after finish", 32'(frame_active), 32'd0);
        end

        // Three 4-bit words, only two tx words, consumer stalled.
        rx_ready = 1'b0;
        tx_write(16'h0009);
        start_frame(1'b0, 4'd3);
        tx_write(16'h0006);
        udr_flag = 1'b0;
        send_word(4, 16'h0005, got);
        chk("w0 miso", 32'(got), 32'h9);
        chk("w0 rx_data", 32'(last_rxd), 32'h5);
        chk("w0 rx_overrun", 32'(last_ovr), 32'd0);
        chk("w0 underrun", 32'(udr_flag), 32'd0);
        udr_flag = 1'b0;
        send_word(4, 16'h000C, got);
        chk("w1 miso", 32'(got), 32'h6);
        chk("w1 rx_valid", 32'(last_rxv), 32'd1);
        chk("w1 rx_data kept", 32'(last_rxd), 32'h5);
        chk("w1 rx_overrun", 32'(last_ovr), 32'd1);
        chk("w1 underrun on next load", 32'(udr_flag), 32'd1);
        send_word(4, 16'h0003, got);
        chk("w2 miso zero", 32'(got), 32'h0);
        rx_ready = 1'b1;
        cyc();
        chk("rx_valid cleared by ready", 32'(rx_valid), 32'd0);
        end_frame();

        // Finish after 5 of 8 bits.
        tx_write(16'h00C3);
        start_frame(1'b0, 4'd7);
        mv = 16'h00FF;
        got = '0;
        for (int i = 7; i >= 3; i--) begin
            do_bit(mv[i], b);
            got[i] = b;
        end
        chk("partial miso bits", 32'(got[7:3]), 32'h18);
        tx_write(16'h0096);
        end_frame();
        cyc();
        chk("partial no rx_valid", 32'(rx_valid), 32'd0);
        chk("held tx word kept", 32'(tx_ready), 32'd0);

        // Edges in IDLE and start+finish together change nothing.
        pulse(1'b1);
        pulse(1'b0);
        spi_start  = 1'b1;
        spi_finish = 1'b1;
        cyc();
        spi_start  = 1'b0;
        spi_finish = 1'b0;
        chk("idle frame_active", 32'(frame_active), 32'd0);
        chk("idle miso_oe", 32'(miso_oe), 32'd0);
        chk("idle miso", 32'(miso), 32'd0);
        chk("idle tx_ready", 32'(tx_ready), 32'd0);
        chk("idle rx_valid", 32'(rx_valid), 32'd0);
        chk("idle tx_underrun", 32'(tx_underrun), 32'd0);

        // Next frame after the aborted one is clean and uses the held word.
        start_frame(1'b0, 4'd7);
        chk("clean start underrun", 32'(tx_underrun), 32'd0);
        send_word(8, 16'h00A7, got);
        chk("clean miso", 32'(got), 32'h96);
        chk("clean rx_valid", 32'(last_rxv), 32'd1);
        chk("clean rx_data", 32'(last_rxd), 32'hA7);
        end_frame();

        // Asynchronous reset mid-word.
        tx_write(16'h00FF);
        start_frame(1'b0, 4'd7);
        for (int i = 0; i < 3; i++) do_bit(1'b1, b);
        chk("pre-reset frame_active", 32'(frame_active), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async rst miso", 32'(miso), 32'd0);
        chk("async rst miso_oe", 32'(miso_oe), 32'd0);
        chk("async rst frame_active", 32'(frame_active), 32'd0);
        chk("async rst tx_ready", 32'(tx_ready), 32'd1);
        chk("async rst rx_valid", 32'(rx_valid), 32'd0);
        chk("async rst rx_data", 32'(rx_data), 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        tx_write(16'h005C);
        start_frame(1'b1, 4'd7);
        send_word(8, 16'h00E1, got);
        chk("post-reset miso", 32'(got), 32'h5C);
        chk("post-reset rx_data", 32'(last_rxd), 32'hE1);
        end_frame();

        // Random multi-word frames against the word-level model.
        for (int f = 0; f < 24; f++) begin
            r_ph  = 1'($urandom);
            r_len = $urandom_range(16, 1);
            r_nw  = $urandom_range(3, 1);
            for (int k = 0; k < 3; k++) begin
                r_tx[k] = 16'($urandom);
                r_mo[k] = 16'($urandom);
            end
            tx_write(r_tx[0]);
            start_frame(r_ph, 4'(r_len - 1));
            spi_width = 4'($urandom);
            for (int k = 0; k < r_nw; k++) begin
                if (r_ph) begin
                    if (k > 0) tx_write(r_tx[k]);
                end else if (k + 1 < r_nw) begin
                    tx_write(r_tx[k + 1]);
                end
                send_word(r_len, r_mo[k], got);
                chk("rand miso word", 32'(got), 32'(mask_w(r_tx[k], r_len)));
                chk("rand rx_valid", 32'(last_rxv), 32'd1);
                chk("rand rx_data", 32'(last_rxd), 32'(mask_w(r_mo[k], r_len)));
                chk("rand rx_overrun", 32'(last_ovr), 32'd0);
            end
            end_frame();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
